// File: rtl/character_ring_buffer_pkg.sv
// Shared keyboard defaults for the character ring buffer.
package character_ring_buffer_pkg;
    localparam int CHAR_WIDTH     = 64;
    localparam int CHAR_BUF_DEPTH = 32;
endpackage

// File: rtl/character_ring_buffer_if.sv
// Bus between the keyboard scan side / CPU side and the character ring buffer.
interface character_ring_buffer_if
    import character_ring_buffer_pkg::*;
#(
    parameter int WIDTH = CHAR_WIDTH,
    parameter int DEPTH = CHAR_BUF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
);
    logic             clear;
    logic             status_clear;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic [WIDTH-1:0] pop_data;
    logic [AW-1:0]    select_a;
    logic [AW-1:0]    select_b;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             valid_a;
    logic             valid_b;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, status_clear, push, push_data, pop, select_a, select_b,
        input  pop_data, out_a, out_b, valid_a, valid_b, count, empty, full,
               overflow, underflow
    );

    modport slave (
        input  clear, status_clear, push, push_data, pop, select_a, select_b,
        output pop_data, out_a, out_b, valid_a, valid_b, count, empty, full,
               overflow, underflow
    );
endinterface

// File: rtl/character_ring_buffer_register.sv
// Parametrised load-enable register used as one storage slot.
module char_register #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // Capture d when load is asserted; async clear on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)    q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/character_ring_buffer_ring_pointer.sv
// AW-bit wrapping pointer with increment and synchronous clear.
module ring_pointer #(
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] ptr
);
    // Clear wins over increment; wrap-around is the natural AW-bit overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     ptr <= '0;
        else if (clear) ptr <= '0;
        else if (inc)   ptr <= ptr + AW'(1);
    end
endmodule

// File: rtl/character_ring_buffer.sv
// FIFO-ordered character store with head-relative peek ports and sticky status.
module character_ring_buffer
    import character_ring_buffer_pkg::*;
#(
    parameter int WIDTH = CHAR_WIDTH,
    parameter int DEPTH = CHAR_BUF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    character_ring_buffer_if.slave  bus
);
    logic [AW-1:0]               head;
    logic [AW-1:0]               tail;
    logic [AW:0]                 count_q;
    logic [DEPTH-1:0][WIDTH-1:0] storage;
    logic [DEPTH-1:0]            load;
    logic                        is_full, is_empty;
    logic                        push_ok, pop_ok, ovf_set, unf_set;
    logic                        overflow_q, underflow_q;
    logic [AW-1:0]               idx_a, idx_b;

    assign is_full  = (count_q == (AW+1)'(DEPTH));
    assign is_empty = (count_q == '0);

    // Clear overrides both sides, so neither operation nor its error is taken.
    assign push_ok = bus.push && (!is_full || bus.pop) && !bus.clear;
    assign pop_ok  = bus.pop && !is_empty && !bus.clear;
    assign ovf_set = bus.push && is_full && !bus.pop && !bus.clear;
    assign unf_set = bus.pop && is_empty && !bus.clear;

    ring_pointer #(.AW(AW)) u_head (
        .clock(clock), .reset(reset), .clear(bus.clear), .inc(pop_ok), .ptr(head)
    );
    ring_pointer #(.AW(AW)) u_tail (
        .clock(clock), .reset(reset), .clear(bus.clear), .inc(push_ok), .ptr(tail)
    );

    // Occupancy tracks accepted push minus accepted pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         count_q <= '0;
        else if (bus.clear) count_q <= '0;
        else                count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    // Sticky errors; a fresh error beats status_clear in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_set)               overflow_q  <= 1'b1;
            else if (bus.status_clear) overflow_q  <= 1'b0;
            if (unf_set)               underflow_q <= 1'b1;
            else if (bus.status_clear) underflow_q <= 1'b0;
        end
    end

    // One-hot write enable at the tail slot.
    always_comb begin
        load       = '0;
        load[tail] = push_ok;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        char_register #(.W(WIDTH)) u_slot (
            .clock(clock), .reset(reset), .load(load[g]),
            .d(bus.push_data), .q(storage[g])
        );
    end

    // Head-relative peek; offsets beyond the occupancy read as zero.
    assign idx_a       = head + bus.select_a;
    assign idx_b       = head + bus.select_b;
    assign bus.valid_a = ({1'b0, bus.select_a} < count_q);
    assign bus.valid_b = ({1'b0, bus.select_b} < count_q);
    assign bus.out_a   = bus.valid_a ? storage[idx_a] : '0;
    assign bus.out_b   = bus.valid_b ? storage[idx_b] : '0;
    assign bus.pop_data = is_empty ? '0 : storage[head];

    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_character_ring_buffer.sv
// Self-checking bench for character_ring_buffer with DEPTH=4.
module tb_character_ring_buffer;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [WIDTH-1:0] sb[$];

    character_ring_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    character_ring_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             push;
        logic [WIDTH-1:0] data;
        logic             pop;
        logic [1:0]       sa;
        logic [1:0]       sb;
        int               cnt;
        logic [WIDTH-1:0] ea;
        logic             va;
        logic [WIDTH-1:0] eb;
        logic             vb;
        logic             ovf;
        logic             unf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; the scoreboard checks the popped word before the edge.
    task automatic drive(input logic p, input logic [WIDTH-1:0] d, input logic q, input logic clr);
        bus.push  = p;
        bus.push_data = d;
        bus.pop   = q;
        bus.clear = clr;
        #1;
        if (!clr) begin
            if (q && sb.size() > 0) check("pop_data", bus.pop_data, sb.pop_front());
            if (p && sb.size() < DEPTH) sb.push_back(d);
        end
        @(posedge clock);
        #1;
        if (clr) sb.delete();
    endtask

    initial begin
        bus.clear = 0; bus.status_clear = 0; bus.push = 0; bus.push_data = '0;
        bus.pop = 0; bus.select_a = '0; bus.select_b = '0;
        reset = 1'b0;
        #12;
        check("reset_count", 64'(bus.count), 64'd0);
        check("reset_empty", 64'(bus.empty), 64'd1);
        check("reset_full", 64'(bus.full), 64'd0);
        check("reset_pop_data", bus.pop_data, 64'd0);
        check("reset_valid_a", 64'(bus.valid_a), 64'd0);
        check("reset_out_a", bus.out_a, 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        //            push data    pop sa sb cnt ea      va eb      vb ovf unf
        vecs[0]  = '{1, 64'h41, 0, 0, 1, 1, 64'h41, 1, 64'h0,  0, 0, 0};
        vecs[1]  = '{1, 64'h42, 0, 0, 1, 2, 64'h41, 1, 64'h42, 1, 0, 0};
        vecs[2]  = '{1, 64'h43, 0, 2, 3, 3, 64'h43, 1, 64'h0,  0, 0, 0};
        vecs[3]  = '{1, 64'h44, 0, 3, 0, 4, 64'h44, 1, 64'h41, 1, 0, 0};
        vecs[4]  = '{1, 64'h45, 0, 3, 0, 4, 64'h44, 1, 64'h41, 1, 1, 0};
        vecs[5]  = '{1, 64'h46, 1, 0, 3, 4, 64'h42, 1, 64'h46, 1, 1, 0};
        vecs[6]  = '{0, 64'h0,  1, 0, 2, 3, 64'h43, 1, 64'h46, 1, 1, 0};
        vecs[7]  = '{0, 64'h0,  1, 0, 1, 2, 64'h44, 1, 64'h46, 1, 1, 0};
        vecs[8]  = '{0, 64'h0,  1, 0, 1, 1, 64'h46, 1, 64'h0,  0, 1, 0};
        vecs[9]  = '{0, 64'h0,  1, 0, 1, 0, 64'h0,  0, 64'h0,  0, 1, 0};
        vecs[10] = '{1, 64'h55, 1, 0, 1, 1, 64'h55, 1, 64'h0,  0, 1, 1};

        for (int i = 0; i < 11; i++) begin
            bus.select_a = vecs[i].sa;
            bus.select_b = vecs[i].sb;
            drive(vecs[i].push, vecs[i].data, vecs[i].pop, 1'b0);
            check($sformatf("v%0d_count", i), 64'(bus.count), 64'(vecs[i].cnt));
            check($sformatf("v%0d_out_a", i), bus.out_a, vecs[i].ea);
            check($sformatf("v%0d_valid_a", i), 64'(bus.valid_a), 64'(vecs[i].va));
            check($sformatf("v%0d_out_b", i), bus.out_b, vecs[i].eb);
            check($sformatf("v%0d_valid_b", i), 64'(bus.valid_b), 64'(vecs[i].vb));
            check($sformatf("v%0d_overflow", i), 64'(bus.overflow), 64'(vecs[i].ovf));
            check($sformatf("v%0d_underflow", i), 64'(bus.underflow), 64'(vecs[i].unf));
            check($sformatf("v%0d_empty", i), 64'(bus.empty), 64'(vecs[i].cnt == 0));
            check($sformatf("v%0d_full", i), 64'(bus.full), 64'(vecs[i].cnt == DEPTH));
        end

        // Drain the 0x55 word, then read pop_data while empty.
        bus.select_a = '0;
        drive(0, '0, 1, 0);
        check("drain_count", 64'(bus.count), 64'd0);
        check("empty_pop_data", bus.pop_data, 64'd0);

        // status_clear alone zeroes both flags.
        bus.status_clear = 1'b1;
        drive(0, '0, 0, 0);
        check("sclr_overflow", 64'(bus.overflow), 64'd0);
        check("sclr_underflow", 64'(bus.underflow), 64'd0);

        // A new underflow in the same cycle as status_clear keeps the flag.
        drive(0, '0, 1, 0);
        check("sclr_race_underflow", 64'(bus.underflow), 64'd1);
        check("sclr_race_overflow", 64'(bus.overflow), 64'd0);
        bus.status_clear = 1'b0;

        // Clear with a simultaneous push flushes the queue; flags stay.
        drive(1, 64'h61, 0, 0);
        drive(1, 64'h62, 0, 0);
        check("preclr_count", 64'(bus.count), 64'd2);
        drive(1, 64'h63, 0, 1);
        check("clr_count", 64'(bus.count), 64'd0);
        check("clr_empty", 64'(bus.empty), 64'd1);
        check("clr_pop_data", bus.pop_data, 64'd0);
        check("clr_underflow_kept", 64'(bus.underflow), 64'd1);
        drive(0, '0, 0, 0);
        check("postclr_count", 64'(bus.count), 64'd0);

        // Queue restarts at slot 0 after clear.
        drive(1, 64'h70, 0, 0);
        check("restart_count", 64'(bus.count), 64'd1);
        check("restart_pop_data", bus.pop_data, 64'h70);

        // Reset asserted between edges takes effect without a clock.
        bus.push = 0; bus.pop = 0;
        #2;
        reset = 1'b0;
        #1;
        check("areset_count", 64'(bus.count), 64'd0);
        check("areset_empty", 64'(bus.empty), 64'd1);
        check("areset_underflow", 64'(bus.underflow), 64'd0);
        check("areset_pop_data", bus.pop_data, 64'd0);
        #5;
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
